// File: rtl/glitch_pulser.sv
// glitch_pulser
//   Armed, trigger-synchronised single-pulse generator. An arm request in
//   IDLE latches delay/width/holdoff. A later rising edge on trig starts
//   the sequence: wait delay cycles, drive glitch for width cycles, wait
//   holdoff cycles, then strobe done for one cycle.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for arm; latched values are held
//   ARMED | waiting for a rising edge on trig
//   DELAY | counting down the latched delay
//   PULSE | glitch high, counting down the latched width
//   HOLD  | counting down the latched holdoff before done
//
// Ports
//   clk      in   single clock, rising edge
//   clr      in   synchronous active-high reset
//   arm      in   arm request, honoured only in IDLE
//   abort    in   cancel any active sequence (no done)
//   trig     in   synchronous, debounced trigger; rising edge fires
//   delay    in   CW  trigger edge to pulse start, in cycles
//   width    in   CW  pulse length in cycles (0 = no pulse)
//   holdoff  in   CW  pulse end to done, in cycles
//   armed    out  high in ARMED
//   busy     out  high in any state other than IDLE
//   glitch   out  the registered pulse
//   done     out  one-cycle completion strobe
module glitch_pulser #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig,
  input  logic [CW-1:0] delay,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] holdoff,
  output logic          armed,
  output logic          busy,
  output logic          glitch,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t        state;
  logic          trig_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] delay_lat;
  logic [CW-1:0] width_lat;
  logic [CW-1:0] holdoff_lat;

  // Counters are loaded with N for DELAY and N-1 for PULSE/HOLD. DELAY
  // spends one extra cycle because the trigger edge itself is the first
  // edge of the sequence, which gives a one-cycle latency for delay=0.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      trig_q      <= 1'b0;
      cnt         <= ZERO;
      delay_lat   <= ZERO;
      width_lat   <= ZERO;
      holdoff_lat <= ZERO;
      armed       <= 1'b0;
      busy        <= 1'b0;
      glitch      <= 1'b0;
      done        <= 1'b0;
    end else begin
      trig_q <= trig;
      done   <= 1'b0;

      if (abort && state != IDLE) begin
        // abort takes priority over trigger edges and counter expiry
        state  <= IDLE;
        armed  <= 1'b0;
        busy   <= 1'b0;
        glitch <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm && !abort) begin
              delay_lat   <= delay;
              width_lat   <= width;
              holdoff_lat <= holdoff;
              state       <= ARMED;
              armed       <= 1'b1;
              busy        <= 1'b1;
            end
          end

          ARMED: begin
            if (trig && !trig_q) begin
              state <= DELAY;
              cnt   <= delay_lat;
              armed <= 1'b0;
            end
          end

          DELAY: begin
            if (cnt == ZERO) begin
              if (width_lat != ZERO) begin
                state  <= PULSE;
                glitch <= 1'b1;
                cnt    <= width_lat - ONE;
              end else if (holdoff_lat != ZERO) begin
                // zero width: skip the pulse but keep the holdoff timing
                state <= HOLD;
                cnt   <= holdoff_lat - ONE;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end

          PULSE: begin
            if (cnt == ZERO) begin
              glitch <= 1'b0;
              if (holdoff_lat != ZERO) begin
                state <= HOLD;
                cnt   <= holdoff_lat - ONE;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end

          HOLD: begin
            if (cnt == ZERO) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - ONE;
            end
          end

          default: begin
            state  <= IDLE;
            armed  <= 1'b0;
            busy   <= 1'b0;
            glitch <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glitch_pulser.sv
// tb_glitch_pulser
//   Directed bench for glitch_pulser. Each sequence is launched by a trig
//   rising edge sampled at relative edge k=0; expected edges come from the
//   timing rules: glitch rises at 1+D, falls at 1+D+W, done at 1+D+W+H.
module tb_glitch_pulser;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic          arm;
  logic          abort;
  logic          trig;
  logic [CW-1:0] delay;
  logic [CW-1:0] width;
  logic [CW-1:0] holdoff;
  logic          armed;
  logic          busy;
  logic          glitch;
  logic          done;

  int checks   = 0;
  int failures = 0;

  glitch_pulser #(.CW(CW)) dut (
    .clk     (clk),
    .clr     (clr),
    .arm     (arm),
    .abort   (abort),
    .trig    (trig),
    .delay   (delay),
    .width   (width),
    .holdoff (holdoff),
    .armed   (armed),
    .busy    (busy),
    .glitch  (glitch),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_seq(input string tag, input int d, input int w, input int h);
    delay   = CW'(d);
    width   = CW'(w);
    holdoff = CW'(h);
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
    // scramble inputs: latched values must not follow
    delay   = 16'h0033;
    width   = 16'h0021;
    holdoff = 16'h0017;
    check_val({tag, "_armed"}, int'(armed), 1);
    check_val({tag, "_busy"}, int'(busy), 1);
  endtask

  // Fires the trigger and observes the whole sequence. If inj >= 0, arm is
  // pulsed with different values just before edge inj (must be ignored).
  task automatic run_seq(input string tag, input int d, input int w, input int h,
                         input int inj);
    int rise, fall, high, done_at, done_cnt, busy_at_done;
    int exp_rise, exp_fall;
    rise = -1; fall = -1; high = 0; done_at = -1; done_cnt = 0; busy_at_done = -1;
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    check_val({tag, "_armed_drop"}, int'(armed), 0);
    for (int k = 1; k <= d + w + h + 6; k++) begin
      if (k == inj) begin
        arm = 1'b1; delay = 16'd0; width = 16'd9; holdoff = 16'd0;
      end else begin
        arm = 1'b0;
      end
      tick();
      if (glitch) begin
        high++;
        if (rise < 0) rise = k;
      end else if (rise >= 0 && fall < 0) begin
        fall = k;
      end
      if (done) begin
        done_cnt++;
        done_at = k;
        busy_at_done = int'(busy);
      end
    end
    arm = 1'b0;
    trig = 1'b0;
    exp_rise = (w > 0) ? 1 + d : -1;
    exp_fall = (w > 0) ? 1 + d + w : -1;
    check_val({tag, "_rise"}, rise, exp_rise);
    check_val({tag, "_fall"}, fall, exp_fall);
    check_val({tag, "_high"}, high, w);
    check_val({tag, "_done_at"}, done_at, 1 + d + w + h);
    check_val({tag, "_done_cnt"}, done_cnt, 1);
    check_val({tag, "_busy_at_done"}, busy_at_done, 0);
    check_val({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int n_gl, n_done;
    clr = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
    delay = '0; width = '0; holdoff = '0;
    tick();
    tick();
    check_val("rst_armed", int'(armed), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_glitch", int'(glitch), 0);
    check_val("rst_done", int'(done), 0);
    clr = 1'b0;
    tick();

    // basic, minimum and zero-width sequences
    arm_seq("basic", 3, 2, 4);
    run_seq("basic", 3, 2, 4, -1);
    arm_seq("min", 0, 1, 0);
    run_seq("min", 0, 1, 0, -1);
    arm_seq("zw", 2, 0, 1);
    run_seq("zw", 2, 0, 1, -1);

    // trigger already high when arming must not fire
    trig = 1'b1;
    tick();
    arm_seq("pre", 1, 1, 1);
    n_gl = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (glitch) n_gl++;
    end
    check_val("pre_no_glitch", n_gl, 0);
    check_val("pre_still_armed", int'(armed), 1);
    run_seq("pre_refire", 1, 1, 1, -1);

    // arm while busy is ignored; original timing holds
    arm_seq("arm_busy", 4, 2, 2);
    run_seq("arm_busy", 4, 2, 2, 2);

    // abort on the third pulse cycle
    arm_seq("abort", 1, 10, 2);
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    check_val("abort_pre_glitch", int'(glitch), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_glitch", int'(glitch), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(done), 0);
    arm_seq("abort_rearm", 2, 1, 0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) n_done++;
    end
    check_val("abort_no_done", n_done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort_armed_cancel", int'(busy), 0);
    trig = 1'b0;

    // arm and abort together in IDLE: abort wins
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check_val("arm_abort_busy", int'(busy), 0);
    check_val("arm_abort_armed", int'(armed), 0);

    // clr in the middle of a pulse
    arm_seq("clr", 0, 5, 1);
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    tick();
    check_val("clr_pre_glitch", int'(glitch), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    trig = 1'b0;
    check_val("clr_glitch", int'(glitch), 0);
    check_val("clr_busy", int'(busy), 0);
    check_val("clr_armed", int'(armed), 0);
    check_val("clr_done", int'(done), 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    check_val("clr_no_done", n_done, 0);
    arm_seq("post_clr", 2, 3, 2);
    run_seq("post_clr", 2, 3, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glitch_pulser.md
# glitch_pulser

Armed, trigger-synchronised output pulse generator. It is the drive-side counterpart to the switch input conditioning: it emits one precisely timed, programmable-width pulse on an output pin. After an arm request and a rising edge on an already-conditioned trigger input, it waits a programmed delay, drives `glitch` for a programmed width, waits a holdoff, then reports completion. It sits between the control/register logic and the glitch output pin.

## Interface
- `CW`, default 16: width of the delay, width and holdoff values and of the internal cycle counter.
- `clk` in 1: single clock; all state changes on its rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `arm` in 1: arm request; accepted only in IDLE.
- `abort` in 1: cancels any active sequence.
- `trig` in 1: trigger, already synchronous and debounced; a rising edge fires.
- `delay` in CW: cycles from trigger edge to pulse start; latched on arm acceptance.
- `width` in CW: pulse length in cycles; latched on arm acceptance.
- `holdoff` in CW: cycles after pulse end before done; latched on arm acceptance.
- `armed` out 1: high in ARMED.
- `busy` out 1: high in any state other than IDLE.
- `glitch` out 1: the pulse; registered, glitch-free.
- `done` out 1: one-cycle completion strobe.

## Operation
- States: IDLE, ARMED, DELAY, PULSE, HOLD.
- IDLE:
  - `arm`=1 latches delay/width/holdoff into internal registers and goes to ARMED.
  - Input changes after latching have no effect until the next arm.
- ARMED: a rising edge (`trig`=1 this cycle, `trig_q`=0) moves to DELAY with the counter loaded.
  - `trig_q` is a register updated every cycle in every state. A trigger already high when arming does not fire; `trig` must go low and then high again.
- DELAY: counts D latched cycles, then PULSE. D=0 goes straight to PULSE.
- PULSE: `glitch`=1 for W cycles, then HOLD. W=0 produces no pulse; the sequence still runs and `done` still fires.
- HOLD: counts H cycles, then IDLE with `done`=1 for one cycle. H=0 returns to IDLE immediately after PULSE.
- `abort`=1 in ARMED/DELAY/PULSE/HOLD:
  - Next edge goes to IDLE and `glitch` drops at that edge.
  - `done` is not asserted.
  - abort beats a simultaneous trigger edge or counter expiry.
- `arm` outside IDLE is ignored. `arm` and `abort` together in IDLE: abort wins, stay IDLE.
- Counter is CW bits, counts down, with no wrap-around. All-ones values give the maximum 2^CW−1 cycles.
- `clr`=1 at any edge forces IDLE and zeroes `trig_q`, the counter and the latched values. This applies mid-pulse too: `glitch` falls at that edge and `done` is not asserted.

## Timing
- Reset values: `armed`=0, `busy`=0, `glitch`=0, `done`=0.
- Edge A (arm=1 in IDLE): `armed`=1 and `busy`=1 from A.
- Edge N (trig edge sampled in ARMED): `armed`=0 from N.
- `glitch` rises at edge N+1+D and falls at edge N+1+D+W. Exactly W cycles high.
- Let E = N+1+D+W.
  - At edge E+H: `done`=1 and `busy`=0, for one cycle.
  - `done` deasserts at E+H+1.
- New arm is accepted no earlier than edge E+H+1.
- All outputs are registered. No combinational path from inputs to outputs.
- Trigger-to-pulse latency with D=0 is exactly 1 cycle.

## Test plan
- Basic sequence: D=3, W=2, H=4; arm, then trig 0→1 at edge N=10 → `glitch` high at edges 14–15 (falls at 16), `done` at 20, `busy` low from 20.
- Minimum values: D=0, W=1, H=0; trig edge at N → `glitch` high only in cycle N+1, `done` at N+2.
- Zero width: D=2, W=0, H=1; trig at N → `glitch` never high, `done` at N+4.
- Trigger already high when armed: `trig` held at 1 through arm and for 20 cycles → no fire. Then trig 1→0→1 fires normally.
- Abort mid-pulse: D=1, W=10; abort at third pulse cycle → `glitch` falls at that edge, `done` never asserts, state IDLE, new arm is accepted next cycle.
- Reset mid-pulse and arm while busy: `clr`=1 during PULSE → all outputs 0 at that edge. In a separate run, `arm` pulsed with new values during DELAY → ignored; the original D/W/H timing is unchanged.
